permute_fwd_pipe: RTL

Odd-pipe result carrier that sits directly downstream of the Permute unit. It captures the stage-3 Permute result and carries it through stages 4-7 to the register-file write port. Every in-flight result is exposed to a two-port forwarding lookup used by the register file/forwarding stage. It also applies branch flush and pipeline stall to those in-flight results.

---
 rtl/spu_pkg.sv | 18 +
 rtl/fwd_stage_reg.sv | 28 ++
 rtl/permute_fwd_pipe.sv | 104 ++++++++++
 3 files changed

// File: rtl/spu_pkg.sv
// Shared types for the SPU odd-pipe result carrier: quadword/register types and the
// forwarding entry carried through each pipeline stage.
package spu_pkg;

   localparam int QW_BITS          = 128;
   localparam int REG_ADDR_BITS    = 7;
   localparam int PERMUTE_WB_STAGE = 3;

   typedef logic [0:QW_BITS-1]       quadword_t;
   typedef logic [0:REG_ADDR_BITS-1] reg_addr_t;

   typedef struct packed {
      quadword_t data;
      reg_addr_t addr;
      logic      valid;
   } fwd_entry_t;

endpackage

// File: rtl/fwd_stage_reg.sv
// One in-flight result register: loads when not held; while held, a flush clears
// only the valid bit so the stage keeps its (now dead) contents.
module fwd_stage_reg
   import spu_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       hold_i,
   input  logic       flush_i,
   input  fwd_entry_t entry_d,
   output fwd_entry_t entry_o
);

   fwd_entry_t entry_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         entry_q <= '0;
      end else if (!hold_i) begin
         entry_q <= entry_d;
      end else if (flush_i) begin
         entry_q.valid <= 1'b0;
      end
   end

   assign entry_o = entry_q;

endmodule

// File: rtl/permute_fwd_pipe.sv
// Permute result carrier, stages 4..3+DEPTH, with two-port youngest-first forwarding.
// Define PERMUTE_FWD_BYPASS_EN to also forward the live stage-3 input.
module permute_fwd_pipe
   import spu_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int FLUSH_STAGES = 2
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [0:127] wb_data,
   input  logic [0:6]   wb_reg_addr,
   input  logic         wb_enable_reg_write,
   input  logic         branch_is_taken,
   input  logic         stall,
   input  logic [0:6]   fwd_addr_a,
   input  logic [0:6]   fwd_addr_b,
   output logic         fwd_hit_a,
   output logic         fwd_hit_b,
   output logic [0:127] fwd_data_a,
   output logic [0:127] fwd_data_b,
   output logic [0:127] rf_wr_data,
   output logic [0:6]   rf_wr_addr,
   output logic         rf_wr_en
);

   fwd_entry_t       cap_entry;
   fwd_entry_t       stage_d [DEPTH];
   fwd_entry_t       stage_q [DEPTH];
   logic [DEPTH-1:0] flush_v;
   logic [DEPTH-1:0] live_v;

   always_comb begin
      cap_entry.data  = wb_data;
      cap_entry.addr  = wb_reg_addr;
      cap_entry.valid = wb_enable_reg_write & ~branch_is_taken;
   end

   // Index 0 is stage 4 (youngest); a stage is live only if valid and not being flushed now.
   always_comb begin
      flush_v = '0;
      live_v  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         flush_v[k] = branch_is_taken && (k < FLUSH_STAGES);
         live_v[k]  = stage_q[k].valid & ~flush_v[k];
      end
   end

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         stage_d[k] = '0;
      end
      stage_d[0] = cap_entry;
      for (int k = 1; k < DEPTH; k++) begin
         stage_d[k]       = stage_q[k-1];
         stage_d[k].valid = live_v[k-1];
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      fwd_stage_reg u_stage (
         .clock   (clock),
         .reset   (reset),
         .hold_i  (stall),
         .flush_i (flush_v[g]),
         .entry_d (stage_d[g]),
         .entry_o (stage_q[g])
      );
   end

   // Walk oldest to youngest so the youngest match is the last one assigned.
   always_comb begin
      fwd_hit_a  = 1'b0;
      fwd_data_a = '0;
      fwd_hit_b  = 1'b0;
      fwd_data_b = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (live_v[k] && (stage_q[k].addr == fwd_addr_a)) begin
            fwd_hit_a  = 1'b1;
            fwd_data_a = stage_q[k].data;
         end
         if (live_v[k] && (stage_q[k].addr == fwd_addr_b)) begin
            fwd_hit_b  = 1'b1;
            fwd_data_b = stage_q[k].data;
         end
      end
`ifdef PERMUTE_FWD_BYPASS_EN
      if (cap_entry.valid && (cap_entry.addr == fwd_addr_a)) begin
         fwd_hit_a  = 1'b1;
         fwd_data_a = cap_entry.data;
      end
      if (cap_entry.valid && (cap_entry.addr == fwd_addr_b)) begin
         fwd_hit_b  = 1'b1;
         fwd_data_b = cap_entry.data;
      end
`endif
   end

   // A held last stage must not write, otherwise it would be written again on release.
   assign rf_wr_data = stage_q[DEPTH-1].data;
   assign rf_wr_addr = stage_q[DEPTH-1].addr;
   assign rf_wr_en   = live_v[DEPTH-1] & ~stall;

endmodule
